// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master) and the
// instruction memory (slave).
`timescale 1ns/1ps
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 64
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
    modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// PC owner and instruction fetcher: IDLE -> REQ -> HOLD loop with fetch timeout to ERR.
// Optional FETCH_PERF_CNT_EN adds saturating fetched/stall performance counters.
`timescale 1ns/1ps
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master imem,
    output logic [31:0]        instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               BrTaken,
    input  logic               UncondBr,
    output logic [ADDR_W-1:0]  pc,
    output logic               fetch_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        ERR
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t            state;
    logic [7:0]        wait_cnt;
    logic [7:0]        wait_cnt_nxt;
    logic [ADDR_W-1:0] b_off;
    logic [ADDR_W-1:0] cbz_off;
    logic [ADDR_W-1:0] next_pc;

    assign imem.imem_addr = pc;
    assign wait_cnt_nxt   = wait_cnt + 8'd1;

    // Branch offsets: sign-extended immediates already scaled by 4 (word addressing).
    assign b_off   = {{(ADDR_W-28){instr[25]}}, instr[25:0], 2'b00};
    assign cbz_off = {{(ADDR_W-21){instr[23]}}, instr[23:5], 2'b00};

    // NOTE: every output of an always_comb block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        next_pc = pc + ADDR_W'(4);
        if (BrTaken) begin
            if (UncondBr) next_pc = pc + b_off;
            else          next_pc = pc + cbz_off;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            instr         <= '0;
            instr_valid   <= 1'b0;
            imem.imem_req <= 1'b0;
            fetch_err     <= 1'b0;
            wait_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state         <= REQ;
                    imem.imem_req <= 1'b1;
                end
                REQ: begin
                    if (imem.imem_ack) begin
                        instr         <= imem.imem_rdata;
                        instr_valid   <= 1'b1;
                        imem.imem_req <= 1'b0;
                        wait_cnt      <= '0;
                        state         <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt_nxt;
                        if (wait_cnt_nxt == MAX_WAIT_C) begin
                            imem.imem_req <= 1'b0;
                            fetch_err     <= 1'b1;
                            state         <= ERR;
                        end
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        pc            <= next_pc;
                        instr_valid   <= 1'b0;
                        imem.imem_req <= 1'b1;
                        state         <= REQ;
                    end
                end
                ERR: begin
                    imem.imem_req <= 1'b0;
                    instr_valid   <= 1'b0;
                    fetch_err     <= 1'b1;
                end
                default: state <= ERR;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic fetched_evt;
    logic stall_evt;

    assign fetched_evt = (state == HOLD) && instr_ready;
    assign stall_evt   = ((state == REQ) && !imem.imem_ack) || ((state == HOLD) && !instr_ready);

    // Counters saturate rather than wrap; ERR is neither REQ nor HOLD so both freeze there.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (fetched_evt && (perf_fetched != 32'hFFFF_FFFF)) perf_fetched <= perf_fetched + 32'd1;
            if (stall_evt   && (perf_stall   != 32'hFFFF_FFFF)) perf_stall   <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, randomized
// transactions against a transaction-level PC model, and reset/timeout sequences.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam int unsigned ADDR_W   = 64;
    localparam int unsigned MAX_WAIT = 15;
    localparam logic [63:0] RST_PC   = 64'd0;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        BrTaken;
    logic        UncondBr;
    logic [63:0] pc;
    logic        fetch_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    instr_fetch_unit_if #(.ADDR_W(ADDR_W)) imem_bus ();

    instr_fetch_unit #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RST_PC),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem       (imem_bus.master),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .BrTaken    (BrTaken),
        .UncondBr   (UncondBr),
        .pc         (pc),
        .fetch_err  (fetch_err)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [63:0] model_pc;
    longint      exp_fetched;
    longint      exp_stall;

    typedef struct {
        logic [31:0] word;
        int          lat;
        int          stall;
        logic        bt;
        logic        ub;
        logic [63:0] exp_next;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Next PC from the architectural rule: signed immediate times four, modulo 2^64.
    function automatic logic [63:0] ref_next(input logic [63:0] p, input logic [31:0] w,
                                             input logic bt, input logic ub);
        longint off;
        if (!bt) return p + 64'd4;
        if (ub) begin
            off = longint'(w[25:0]);
            if (w[25]) off = off - (longint'(1) << 26);
        end else begin
            off = longint'(w[23:5]);
            if (w[23]) off = off - (longint'(1) << 19);
        end
        return p + 64'(off * 4);
    endfunction

    task automatic do_reset();
        reset             = 1'b1;
        imem_bus.imem_ack = 1'b0;
        instr_ready       = 1'b0;
        BrTaken           = 1'b0;
        UncondBr          = 1'b0;
        step();
        step();
        check("rst pc", pc, RST_PC);
        check("rst instr", instr, 0);
        check("rst valid", instr_valid, 0);
        check("rst req", imem_bus.imem_req, 0);
        check("rst err", fetch_err, 0);
        reset = 1'b0;
        step();
        check("post-rst req", imem_bus.imem_req, 1);
        check("post-rst addr", imem_bus.imem_addr, RST_PC);
        check("post-rst valid", instr_valid, 0);
        model_pc    = RST_PC;
        exp_fetched = 0;
        exp_stall   = 0;
    endtask

    // One full fetch starting in REQ: lat no-ack cycles, ack, stall cycles of
    // back-pressure, then consumption with the given branch inputs.
    task automatic fetch_txn(input string tag, input logic [31:0] word, input int lat,
                             input int stall, input logic bt, input logic ub,
                             input logic [63:0] exp_next);
        check({tag, " req"}, imem_bus.imem_req, 1);
        check({tag, " addr"}, imem_bus.imem_addr, model_pc);
        check({tag, " valid in REQ"}, instr_valid, 0);
        for (int i = 0; i < lat; i++) begin
            imem_bus.imem_ack   = 1'b0;
            imem_bus.imem_rdata = $urandom;
            instr_ready         = 1'($urandom_range(0, 1));
            BrTaken             = 1'($urandom_range(0, 1));
            UncondBr            = 1'($urandom_range(0, 1));
            step();
            check({tag, " wait req"}, imem_bus.imem_req, 1);
            check({tag, " wait addr"}, imem_bus.imem_addr, model_pc);
            check({tag, " wait valid"}, instr_valid, 0);
            check({tag, " wait err"}, fetch_err, 0);
        end
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = word;
        instr_ready         = 1'($urandom_range(0, 1));
        step();
        imem_bus.imem_ack = 1'b0;
        check({tag, " valid"}, instr_valid, 1);
        check({tag, " instr"}, instr, {32'd0, word});
        check({tag, " pc"}, pc, model_pc);
        check({tag, " hold req"}, imem_bus.imem_req, 0);
        for (int i = 0; i < stall; i++) begin
            instr_ready         = 1'b0;
            imem_bus.imem_ack   = 1'($urandom_range(0, 1));
            imem_bus.imem_rdata = $urandom;
            BrTaken             = 1'($urandom_range(0, 1));
            UncondBr            = 1'($urandom_range(0, 1));
            step();
            check({tag, " stall valid"}, instr_valid, 1);
            check({tag, " stall instr"}, instr, {32'd0, word});
            check({tag, " stall pc"}, pc, model_pc);
            check({tag, " stall req"}, imem_bus.imem_req, 0);
        end
        imem_bus.imem_ack = 1'b0;
        instr_ready       = 1'b1;
        BrTaken           = bt;
        UncondBr          = ub;
        step();
        instr_ready = 1'b0;
        BrTaken     = 1'b0;
        UncondBr    = 1'b0;
        exp_fetched = exp_fetched + 1;
        exp_stall   = exp_stall + lat + stall;
        model_pc    = exp_next;
        check({tag, " next req"}, imem_bus.imem_req, 1);
        check({tag, " next addr"}, imem_bus.imem_addr, model_pc);
        check({tag, " next valid"}, instr_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic        bt;
        logic        ub;
        int          lat;
        logic [63:0] hold_pc;

        vecs[0]  = '{32'h9100_0421, 0,  0, 1'b0, 1'b0, 64'h4};
        vecs[1]  = '{32'h1400_0003, 1,  0, 1'b1, 1'b1, 64'h10};
        vecs[2]  = '{32'h1400_0003, 2,  5, 1'b1, 1'b1, 64'h1C};
        vecs[3]  = '{32'hB400_0020, 0,  1, 1'b1, 1'b0, 64'h20};
        vecs[4]  = '{32'hB4FF_FFE0, 14, 0, 1'b1, 1'b0, 64'h1C};
        vecs[5]  = '{32'hB400_0020, 3,  2, 1'b0, 1'bx, 64'h20};
        vecs[6]  = '{32'h17FF_FFF8, 0,  0, 1'b1, 1'b1, 64'h0};
        vecs[7]  = '{32'h1600_0000, 1,  0, 1'b1, 1'b1, 64'hFFFF_FFFF_F800_0000};
        vecs[8]  = '{32'h15FF_FFFF, 0,  3, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC};
        vecs[9]  = '{32'hD503_201F, 0,  0, 1'b0, 1'b1, 64'h0};
        vecs[10] = '{32'h1400_0003, 0,  0, 1'b1, 1'b0, 64'h0};
        vecs[11] = '{32'h9100_0421, 2,  1, 1'b0, 1'b0, 64'h4};

        imem_bus.imem_rdata = 32'd0;
        do_reset();

        for (int i = 0; i < 12; i++)
            fetch_txn($sformatf("vec%0d", i), vecs[i].word, vecs[i].lat, vecs[i].stall,
                      vecs[i].bt, vecs[i].ub, vecs[i].exp_next);

        for (int i = 0; i < 150; i++) begin
            w   = $urandom;
            bt  = 1'($urandom_range(0, 1));
            ub  = 1'($urandom_range(0, 1));
            lat = ($urandom_range(0, 9) == 0) ? int'(MAX_WAIT) - 1 : int'($urandom_range(0, 4));
            fetch_txn($sformatf("rnd%0d", i), w, lat, int'($urandom_range(0, 3)), bt, ub,
                      ref_next(model_pc, w, bt, ub));
        end

`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched", {32'd0, perf_fetched}, 64'(exp_fetched));
        check("perf_stall", {32'd0, perf_stall}, 64'(exp_stall));
`endif

        // Reset while holding an instruction with instr_ready asserted.
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'hCAFE_F00D;
        step();
        imem_bus.imem_ack = 1'b0;
        check("hold-rst pre valid", instr_valid, 1);
        reset       = 1'b1;
        instr_ready = 1'b1;
        BrTaken     = 1'b1;
        step();
        instr_ready = 1'b0;
        BrTaken     = 1'b0;
        check("hold-rst valid", instr_valid, 0);
        check("hold-rst pc", pc, RST_PC);
        check("hold-rst instr", instr, 0);
        check("hold-rst req", imem_bus.imem_req, 0);
        reset = 1'b0;
        step();
        check("hold-rst restart req", imem_bus.imem_req, 1);
        check("hold-rst restart addr", imem_bus.imem_addr, RST_PC);

        // Reset in REQ with an ack on the same edge: the ack must be dropped.
        reset               = 1'b1;
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_bus.imem_ack = 1'b0;
        check("req-rst instr", instr, 0);
        check("req-rst pc", pc, RST_PC);
        check("req-rst req", imem_bus.imem_req, 0);
        check("req-rst valid", instr_valid, 0);
        reset = 1'b0;
        step();
        model_pc = RST_PC;
        fetch_txn("restart", 32'h9100_0421, 0, 0, 1'b0, 1'b0, RST_PC + 64'd4);

        // Timeout: MAX_WAIT REQ cycles without ack lead to ERR.
        for (int i = 0; i < int'(MAX_WAIT) - 1; i++) begin
            imem_bus.imem_ack = 1'b0;
            step();
            check("tmo wait req", imem_bus.imem_req, 1);
            check("tmo wait err", fetch_err, 0);
        end
        step();
        check("tmo err", fetch_err, 1);
        check("tmo req", imem_bus.imem_req, 0);
        check("tmo valid", instr_valid, 0);
        hold_pc = pc;
        for (int i = 0; i < 4; i++) begin
            imem_bus.imem_ack   = 1'b1;
            imem_bus.imem_rdata = $urandom;
            instr_ready         = 1'b1;
            BrTaken             = 1'($urandom_range(0, 1));
            step();
            check("err sticky", fetch_err, 1);
            check("err req", imem_bus.imem_req, 0);
            check("err valid", instr_valid, 0);
            check("err pc", pc, hold_pc);
            check("err instr", instr, 64'h9100_0421);
        end
        do_reset();
        fetch_txn("after-err", 32'h1400_0003, 1, 1, 1'b1, 1'b1, RST_PC + 64'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
